// File: rtl/write_enable_decoder.sv
// Registered one-hot write-enable decoder for the register-file write port.
// Optional macro WE_DEC_ZERO_PROTECT_EN: register 0 is read-only and never enabled.
module write_enable_decoder #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               We,
    input  logic [ADDR_W-1:0]  Awr,
    output logic [NUM_OUT-1:0] WEd,
    output logic               WEd_any,
    output logic [ADDR_W-1:0]  Awr_q,
    output logic               addr_err
);

    // One extra bit so NUM_OUT == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_OUT);

    function automatic logic [NUM_OUT-1:0] onehot(input logic [ADDR_W-1:0] a,
                                                  input logic              en);
        logic [NUM_OUT-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            r[i] = en && (a == ADDR_W'(i));
        end
        return r;
    endfunction

    logic               in_range_p0;
    logic               hit_p0;
    logic               err_p0;
    logic [NUM_OUT-1:0] wed_p0;

    logic [NUM_OUT-1:0] wed_p1;
    logic               any_p1;
    logic [ADDR_W-1:0]  awr_p1;
    logic               err_p1;

    // Stage p0: combinational decode of the sampled request.
    always_comb begin
        in_range_p0 = ({1'b0, Awr} < LIMIT);
`ifdef WE_DEC_ZERO_PROTECT_EN
        hit_p0      = We && in_range_p0 && (Awr != '0);
`else
        hit_p0      = We && in_range_p0;
`endif
        err_p0      = We && !in_range_p0;
        wed_p0      = onehot(Awr, hit_p0);
    end

    // Stage p1: output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wed_p1 <= '0;
            any_p1 <= 1'b0;
            awr_p1 <= '0;
            err_p1 <= 1'b0;
        end else begin
            wed_p1 <= wed_p0;
            any_p1 <= hit_p0;
            awr_p1 <= Awr;
            err_p1 <= err_p0;
        end
    end

    assign WEd      = wed_p1;
    assign WEd_any  = any_p1;
    assign Awr_q    = awr_p1;
    assign addr_err = err_p1;

endmodule

// File: tb/tb_write_enable_decoder.sv
// Bench for write_enable_decoder: full-size (32) and reduced (24) instances
// driven from shared inputs and checked against an arithmetic reference model.
module tb_write_enable_decoder;

`ifdef WE_DEC_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        We;
    logic [4:0]  Awr;

    logic [31:0] wed32;
    logic        any32;
    logic [4:0]  awrq32;
    logic        err32;
    logic [23:0] wed24;
    logic        any24;
    logic [4:0]  awrq24;
    logic        err24;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    write_enable_decoder #(.ADDR_W(5), .NUM_OUT(32)) dut (
        .clk(clk), .rst(rst), .We(We), .Awr(Awr),
        .WEd(wed32), .WEd_any(any32), .Awr_q(awrq32), .addr_err(err32)
    );

    write_enable_decoder #(.ADDR_W(5), .NUM_OUT(24)) dut24 (
        .clk(clk), .rst(rst), .We(We), .Awr(Awr),
        .WEd(wed24), .WEd_any(any24), .Awr_q(awrq24), .addr_err(err24)
    );

    function automatic logic [31:0] exp_wed(input bit we, input logic [4:0] a, input int n);
        if (!we) return 32'd0;
        if (int'(a) >= n) return 32'd0;
        if (ZP && a == 5'd0) return 32'd0;
        return 32'd1 << a;
    endfunction

    function automatic logic exp_err(input bit we, input logic [4:0] a, input int n);
        if (!we) return 1'b0;
        return int'(a) >= n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wed"},   wed32, 32'd0);
        chk({tag, "_any"},   {31'd0, any32}, 32'd0);
        chk({tag, "_awrq"},  {27'd0, awrq32}, 32'd0);
        chk({tag, "_err"},   {31'd0, err32}, 32'd0);
        chk({tag, "_wed24"}, {8'd0, wed24}, 32'd0);
        chk({tag, "_err24"}, {31'd0, err24}, 32'd0);
    endtask

    // Apply one request, clock it in, check both instances.
    task automatic step(input bit we_v, input logic [4:0] a_v);
        logic [31:0] e32, e24;
        We  = we_v;
        Awr = a_v;
        e32 = exp_wed(we_v, a_v, 32);
        e24 = exp_wed(we_v, a_v, 24);
        @(posedge clk);
        #1;
        chk("wed32",  wed32, e32);
        chk("any32",  {31'd0, any32}, {31'd0, (e32 != 32'd0)});
        chk("awrq32", {27'd0, awrq32}, {27'd0, a_v});
        chk("err32",  {31'd0, err32}, {31'd0, exp_err(we_v, a_v, 32)});
        chk("wed24",  {8'd0, wed24}, e24);
        chk("any24",  {31'd0, any24}, {31'd0, (e24 != 32'd0)});
        chk("err24",  {31'd0, err24}, {31'd0, exp_err(we_v, a_v, 24)});
    endtask

    initial begin
        rst = 1'b1;
        We  = 1'b1;
        Awr = 5'd7;
        #12;
        chk_zero("rst_init");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1'b0;

        step(1'b1, 5'd1);
        chk("single_wed", wed32, 32'h0000_0002);

        step(1'b1, 5'd7);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i));
            if (i == 16) begin
                #2;
                rst = 1'b1;
                #1;
                chk_zero("rst_mid");
                #1;
                rst = 1'b0;
                step(1'b1, 5'd9);
                chk("after_rst_wed", wed32, 32'h0000_0200);
            end
        end
        step(1'b1, 5'd31);
        chk("top_wed", wed32, 32'h8000_0000);

        step(1'b0, 5'd5);
        step(1'b1, 5'd5);
        chk("gate_wed", wed32, 32'h0000_0020);

        step(1'b1, 5'd30);
        chk("oor_err24", {31'd0, err24}, 32'd1);
        step(1'b1, 5'd3);
        chk("oor_next24", {8'd0, wed24}, 32'h0000_0008);

        step(1'b1, 5'd0);
        step(1'b0, 5'bxxxxx);

        for (int i = 0; i < 300; i++) begin
            bit          w;
            logic [4:0]  a;
            w = ($urandom_range(0, 3) != 0);
            a = 5'($urandom_range(0, 31));
            if (!w && ($urandom_range(0, 3) == 0)) a = 5'bxxxxx;
            step(w, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_enable_decoder.md
Name: write_enable_decoder

Overview:
- Registered 5-to-32 one-hot write-enable decoder for the register-file write port.
- Takes the write address Awr and a global write strobe, and drives one enable line WEd[i] per register.
- Sits between the control/writeback stage and the register-file write-enable inputs.
- Output is registered: one clock of latency, glitch-free enables to the register bank.

Parameters:
- ADDR_W, 5, width of write address Awr.
- NUM_OUT, 32, number of enable lines; must satisfy 1 <= NUM_OUT <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- We  input  1  global write strobe; no enable is asserted unless high.
- Awr  input  ADDR_W  write register address.
- WEd  output  NUM_OUT  one-hot (or all-zero) registered write enables; bit i enables register i.
- WEd_any  output  1  registered OR of WEd; high when some enable is asserted this cycle.
- Awr_q  output  ADDR_W  registered copy of Awr, captured every cycle. Downstream logic uses it to align write data with WEd.
- addr_err  output  1  registered flag: high for one cycle after a write request with Awr >= NUM_OUT.

Behaviour:
- Reset (rst=1, asynchronous, any time): WEd=0, WEd_any=0, Awr_q=0, addr_err=0 immediately. Held while rst is high.
- First decode occurs on the first rising clk edge after rst deasserts.
- Each rising edge, with rst low:
  - WEd[i] <= We & (Awr == i), for i in 0..NUM_OUT-1.
  - WEd_any <= We & (Awr < NUM_OUT).
  - Awr_q <= Awr.
  - addr_err <= We & (Awr >= NUM_OUT).
- Latency: exactly 1 cycle from input sampling to outputs. There is no combinational path from inputs to outputs.
- Invariant: popcount(WEd) <= 1 at all times. WEd_any == |WEd always.
- We low: WEd=0 and addr_err=0 on the next cycle, regardless of Awr.
- Out-of-range address (only possible when NUM_OUT < 2**ADDR_W): no enable asserted, addr_err=1.
- Back-to-back writes to different addresses produce consecutive one-hot patterns with no idle cycle between them.
- X/Z on Awr while We=0 must not propagate to WEd.
- No handshake; the block accepts a new request every cycle.

Optional Feature:
- Macro: WE_DEC_ZERO_PROTECT_EN.
- Defined:
  - Address 0 is a hardwired read-only register, so WEd[0] is constantly 0.
  - A request with We=1, Awr=0 yields WEd=0 and WEd_any=0.
  - addr_err stays 0 for that request.
- Not defined: address 0 decodes like any other, so WEd[0] can assert.

Test Plan:
- Reset: rst=1 mid-cycle with We=1, Awr=7 -> WEd=0x00000000, WEd_any=0, Awr_q=0 immediately without a clock edge; all outputs stay 0 while rst is held.
- Single decode: rst=0, We=1, Awr=1 -> after 1 edge WEd=0x00000002, WEd_any=1, Awr_q=1.
- Sweep: We=1, Awr=0..31 on consecutive cycles -> each cycle WEd=1<<(Awr of previous cycle); WEd=0x80000000 for Awr=31. Bit 0 is clear when Awr=0 if WE_DEC_ZERO_PROTECT_EN is defined.
- Strobe gating: We=0, Awr=5 -> WEd=0, WEd_any=0, addr_err=0; then We=1, Awr=5 -> WEd=0x00000020 next cycle.
- Out-of-range: NUM_OUT=24, We=1, Awr=30 -> WEd=0, WEd_any=0, addr_err=1 for one cycle; then Awr=3 -> WEd=0x00000008, addr_err=0.
- Reset mid-stream: during the sweep, assert rst between edges -> outputs clear asynchronously. After release, the next edge with We=1, Awr=9 gives WEd=0x00000200.
